// File: rtl/yl3_scroll_ctrl.sv
// Scroll scheduler for the yl3_interface 8-digit driver: keeps a message buffer,
// steps a wrap/bounce scroll position on a tick and hands out 8-character frames.
module yl3_scroll_ctrl #(
    parameter int MSG_MAX  = 16,
    parameter int TICK_DIV = 125000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_MAX)-1:0]   wr_addr,
    input  logic [7:0]                   wr_char,
    input  logic [$clog2(MSG_MAX):0]     msg_len,
    input  logic                         mode,
    input  logic                         enable,
    input  logic                         hold,
    input  logic                         READY,
    output logic [63:0]                  DATA,
    output logic                         LOAD,
    output logic [$clog2(MSG_MAX):0]     pos,
    output logic                         busy
);
    localparam int AW = $clog2(MSG_MAX);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [7:0]  SPACE  = 8'h20;
    localparam logic [63:0] BLANK  = 64'h2020202020202020;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUILD = 2'd1, S_WAIT = 2'd2} state_t;

    logic [7:0]    buf_r [MSG_MAX];
    state_t        state_r;
    logic [2:0]    bidx_r;
    logic [LW-1:0] rd_idx_r;
    logic [63:0]   shadow_r;
    logic [63:0]   data_r;
    logic          load_r;
    logic [LW-1:0] pos_r;
    logic          dir_r;
    logic          busy_r;
    logic [CW-1:0] cnt_r;
    logic          step_pend_r;
    logic          imm_r;
    logic [LW-1:0] len_q_r;
    logic          mode_q_r;
    logic          en_q_r;

    logic          cfg_change_s;
    logic          run_s;
    logic          tick_wrap_s;
    logic          bounce_s;
    logic [LW-1:0] range_s;
    logic [LW-1:0] next_pos_s;
    logic          next_dir_s;
    logic [LW-1:0] rd_next_s;
    logic [LW-1:0] i_s;
    logic [LW-1:0] off_s;
    logic [7:0]    char_s;

    assign DATA = data_r;
    assign LOAD = load_r;
    assign pos  = pos_r;
    assign busy = busy_r;

    assign cfg_change_s = (msg_len != len_q_r) || (mode != mode_q_r) || (enable && !en_q_r);
    assign run_s        = enable && !hold;
    assign tick_wrap_s  = run_s && (cnt_r == CW'(TICK_DIV - 1));
    assign bounce_s     = mode_q_r && (len_q_r <= LW'(8));
    assign range_s      = LW'(8) - len_q_r;
    assign rd_next_s    = (rd_idx_r + LW'(1) == len_q_r) ? LW'(0) : rd_idx_r + LW'(1);
    assign i_s          = LW'(bidx_r);
    assign off_s        = i_s - pos_r;

    // Next scroll position and direction for one step under the active config
    always_comb begin
        next_pos_s = pos_r;
        next_dir_s = dir_r;
        if (len_q_r == LW'(0)) begin
            next_pos_s = LW'(0);
        end else if (bounce_s) begin
            if (range_s == LW'(0)) begin
                next_pos_s = LW'(0);
            end else if (!dir_r) begin
                if (pos_r >= range_s) begin
                    next_dir_s = 1'b1;
                    next_pos_s = range_s - LW'(1);
                end else begin
                    next_pos_s = pos_r + LW'(1);
                end
            end else begin
                if (pos_r == LW'(0)) begin
                    next_dir_s = 1'b0;
                    next_pos_s = LW'(1);
                end else begin
                    next_pos_s = pos_r - LW'(1);
                end
            end
        end else begin
            next_pos_s = (pos_r + LW'(1) == len_q_r) ? LW'(0) : pos_r + LW'(1);
        end
    end

    // Character for window slot bidx_r; wrap mode walks rd_idx_r modulo the length
    always_comb begin
        char_s = SPACE;
        if (len_q_r == LW'(0)) begin
            char_s = SPACE;
        end else if (bounce_s) begin
            if ((i_s >= pos_r) && (i_s < pos_r + len_q_r)) begin
                char_s = buf_r[off_s[AW-1:0]];
            end else begin
                char_s = SPACE;
            end
        end else begin
            char_s = buf_r[rd_idx_r[AW-1:0]];
        end
    end

    // Message buffer, writable at any time
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MSG_MAX; k++) begin
                buf_r[k] <= SPACE;
            end
        end else if (wr_en) begin
            buf_r[wr_addr] <= wr_char;
        end
    end

    // Tick counter, config tracking and frame FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            bidx_r      <= 3'd0;
            rd_idx_r    <= LW'(0);
            shadow_r    <= BLANK;
            data_r      <= BLANK;
            load_r      <= 1'b0;
            pos_r       <= LW'(0);
            dir_r       <= 1'b0;
            busy_r      <= 1'b0;
            cnt_r       <= CW'(0);
            step_pend_r <= 1'b0;
            imm_r       <= 1'b0;
            len_q_r     <= LW'(0);
            mode_q_r    <= 1'b0;
            en_q_r      <= 1'b0;
        end else begin
            load_r   <= 1'b0;
            len_q_r  <= msg_len;
            mode_q_r <= mode;
            en_q_r   <= enable;
            // A config change restarts the scroll and swallows any coincident tick
            if (cfg_change_s) begin
                cnt_r       <= CW'(0);
                step_pend_r <= 1'b0;
                pos_r       <= LW'(0);
                dir_r       <= 1'b0;
            end else if (run_s) begin
                cnt_r <= tick_wrap_s ? CW'(0) : cnt_r + CW'(1);
                if (tick_wrap_s) begin
                    step_pend_r <= 1'b1;
                end
            end
            case (state_r)
                S_IDLE: begin
                    if (cfg_change_s && enable) begin
                        state_r  <= S_BUILD;
                        busy_r   <= 1'b1;
                        bidx_r   <= 3'd0;
                        rd_idx_r <= LW'(0);
                        imm_r    <= 1'b0;
                    end else if (cfg_change_s) begin
                        imm_r <= 1'b1;
                    end else if (!enable) begin
                        state_r <= S_IDLE;
                    end else if (imm_r) begin
                        state_r  <= S_BUILD;
                        busy_r   <= 1'b1;
                        bidx_r   <= 3'd0;
                        rd_idx_r <= pos_r;
                        imm_r    <= 1'b0;
                    end else if (step_pend_r && !hold) begin
                        state_r     <= S_BUILD;
                        busy_r      <= 1'b1;
                        bidx_r      <= 3'd0;
                        pos_r       <= next_pos_s;
                        dir_r       <= next_dir_s;
                        rd_idx_r    <= next_pos_s;
                        step_pend_r <= tick_wrap_s;
                    end
                end
                S_BUILD: begin
                    shadow_r[{~bidx_r, 3'b000} +: 8] <= char_s;
                    rd_idx_r <= rd_next_s;
                    bidx_r   <= bidx_r + 3'd1;
                    if (bidx_r == 3'd7) begin
                        state_r <= S_WAIT;
                    end
                    if (cfg_change_s) begin
                        imm_r <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cfg_change_s) begin
                        imm_r <= 1'b1;
                    end
                    if (READY) begin
                        data_r  <= shadow_r;
                        load_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_yl3_scroll_ctrl.sv
// Self-checking bench for yl3_scroll_ctrl: table-driven scroll vectors, corner
// sequences and randomized configurations checked against an arithmetic model.
module tb_yl3_scroll_ctrl;
    localparam int MM = 16;
    localparam int TD = 4;
    localparam logic [63:0] BLANK = 64'h2020202020202020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_char = 8'd0;
    logic [4:0]  msg_len = 5'd0;
    logic        mode = 1'b0;
    logic        enable = 1'b0;
    logic        hold = 1'b0;
    logic        READY = 1'b1;
    logic [63:0] DATA;
    logic        LOAD;
    logic [4:0]  pos;
    logic        busy;

    yl3_scroll_ctrl #(.MSG_MAX(MM), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .msg_len(msg_len), .mode(mode), .enable(enable), .hold(hold), .READY(READY),
        .DATA(DATA), .LOAD(LOAD), .pos(pos), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] mem_m [MM];

    typedef struct {
        int          scen;
        int          k;
        logic [63:0] data;
        int          p;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; hold = 1'b0; wr_en = 1'b0;
        msg_len = 5'd0; mode = 1'b0; READY = 1'b1;
        for (int i = 0; i < MM; i++) mem_m[i] = 8'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_one(input int a, input logic [7:0] c);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_char = c;
        mem_m[a] = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_str(input logic [127:0] s, input int n);
        for (int j = 0; j < n; j++) wr_one(j, s[8*(n-1-j) +: 8]);
    endtask

    task automatic wait_load(output logic [63:0] d, output int p, output int cyc, input bit rnd);
        bit done;
        done = 1'b0; d = 64'd0; p = 0; cyc = 0;
        while (!done) begin
            @(posedge clk);
            cyc++;
            #1;
            if (LOAD) begin
                d = DATA; p = int'(pos); done = 1'b1;
            end else if (cyc >= 300) begin
                total++; bad++;
                $display("FAIL load_timeout actual=%0d cycles required=LOAD", cyc);
                done = 1'b1;
            end else if (rnd) begin
                READY = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    // Expected position of the k-th frame after a restart
    function automatic int m_pos(input int len, input bit md, input int k);
        int r, ph;
        if (len == 0) return 0;
        if (md && len <= 8) begin
            r = 8 - len;
            if (r == 0) return 0;
            ph = k % (2 * r);
            return (ph <= r) ? ph : 2 * r - ph;
        end
        return k % len;
    endfunction

    function automatic logic [63:0] m_frame(input int len, input bit md, input int p);
        logic [63:0] f;
        logic [7:0]  c;
        f = BLANK;
        for (int i = 0; i < 8; i++) begin
            c = 8'h20;
            if (len > 0) begin
                if (md && len <= 8) begin
                    if (i >= p && i < p + len) c = mem_m[i - p];
                end else begin
                    c = mem_m[(p + i) % len];
                end
            end
            f[8*(7-i) +: 8] = c;
        end
        return f;
    endfunction

    initial begin
        logic [63:0] d;
        logic [63:0] fr [12];
        int          fp [12];
        int          p, cyc, n, len, p0;
        bit          md;

        tbl[0]  = '{0, 0,  "ABCDEFGH", 0};
        tbl[1]  = '{0, 1,  "BCDEFGHI", 1};
        tbl[2]  = '{0, 2,  "CDEFGHIJ", 2};
        tbl[3]  = '{0, 9,  "JABCDEFG", 9};
        tbl[4]  = '{0, 10, "ABCDEFGH", 0};
        tbl[5]  = '{1, 0,  "HELLO   ", 0};
        tbl[6]  = '{1, 1,  " HELLO  ", 1};
        tbl[7]  = '{1, 2,  "  HELLO ", 2};
        tbl[8]  = '{1, 3,  "   HELLO", 3};
        tbl[9]  = '{1, 4,  "  HELLO ", 2};
        tbl[10] = '{1, 6,  "HELLO   ", 0};

        // Reset values and an empty message
        do_reset();
        chk("rst_data", DATA, BLANK);
        chk("rst_load", 64'(LOAD), 64'd0);
        chk("rst_pos", 64'(pos), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_load(d, p, cyc, 1'b0);
            chk("empty_data", d, BLANK);
            chk("empty_pos", 64'(p), 64'd0);
        end

        // Table-driven bounce (scen 1) then wrap (scen 0) runs
        for (int s = 1; s >= 0; s--) begin
            do_reset();
            rst = 1'b0;
            if (s == 0) write_str(128'("ABCDEFGHIJ"), 10);
            else        write_str(128'("HELLO"), 5);
            @(negedge clk);
            msg_len = (s == 0) ? 5'd10 : 5'd5;
            mode = (s == 1);
            @(negedge clk);
            enable = 1'b1;
            for (int k = 0; k < 11; k++) begin
                wait_load(fr[k], fp[k], cyc, 1'b0);
                if (k == 0) chk("first_latency", 64'(cyc - 1), 64'd9);
            end
            for (int t = 0; t < 11; t++) begin
                if (tbl[t].scen == s) begin
                    chk("tbl_data", fr[tbl[t].k], tbl[t].data);
                    chk("tbl_pos", 64'(fp[tbl[t].k]), 64'(tbl[t].p));
                end
            end
        end

        // Backpressure: READY low across several ticks yields one frame, one step
        READY = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (LOAD) n++;
        end
        chk("bp_no_load", 64'(n), 64'd0);
        READY = 1'b1;
        wait_load(d, p, cyc, 1'b0);
        chk("bp_data", d, 64'("BCDEFGHI"));
        chk("bp_pos", 64'(p), 64'd1);
        chk("bp_latency", 64'(cyc), 64'd1);

        // Hold freezes position and suppresses frames
        hold = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (LOAD) n++;
        end
        chk("hold_loads", 64'(n), 64'd0);
        chk("hold_pos", 64'(pos), 64'd1);

        // Length change mid-scroll restarts at 0 with an immediate frame
        hold = 1'b0;
        msg_len = 5'd5;
        wait_load(d, p, cyc, 1'b0);
        chk("cfg_data", d, 64'("ABCDEABC"));
        chk("cfg_pos", 64'(p), 64'd0);
        chk("cfg_latency", 64'(cyc - 1), 64'd9);

        // Reset in the middle of BUILD abandons the frame
        msg_len = 5'd10;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (LOAD) n++;
        end
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        if (LOAD) n++;
        chk("mid_rst_data", DATA, BLANK);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pos", 64'(pos), 64'd0);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (LOAD) n++;
        end
        chk("mid_rst_noload", 64'(n), 64'd0);

        // Randomized configurations against the reference model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            rst = 1'b0;
            len = $urandom_range(0, 16);
            md = 1'($urandom_range(0, 1));
            if (r == 0) begin len = 8; md = 1'b1; end
            for (int a = 0; a < MM; a++) wr_one(a, 8'($urandom_range(33, 126)));
            @(negedge clk);
            msg_len = 5'(len);
            mode = md;
            @(negedge clk);
            enable = 1'b1;
            for (int k = 0; k < 10; k++) begin
                wait_load(d, p, cyc, 1'b1);
                p0 = m_pos(len, md, k);
                chk("rnd_data", d, m_frame(len, md, p0));
                chk("rnd_pos", 64'(p), 64'(p0));
            end
            READY = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
